// File: rtl/comp_seq_pkg.sv
// comp_seq_pkg: states, mode codes, sizes and window index helper for computation_sequencer (ABT state only with COMP_SEQ_ABORT_EN)
package comp_seq_pkg;
    typedef enum logic [2:0] {
        IDLE, CLR, MAC, LOAD_A, LOAD_B, WAIT, RES
`ifdef COMP_SEQ_ABORT_EN
        , ABT
`endif
    } state_e;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_SYS    = 2'b10;
    localparam logic [1:0] MODE_CUS    = 2'b11;

    localparam int N_PIX   = 4;
    localparam int N_TAP   = 9;
    localparam int N_ROW_A = 4;
    localparam int N_ROW_B = 3;

    function automatic logic [3:0] elem_idx(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
        return 4'(4 * (int'(p[1]) + int'(r)) + int'(p[0]) + int'(c));
    endfunction
endpackage

// File: rtl/conv_index_gen.sv
// conv_index_gen: input-element indices of the 3x3 window for pixel p, tap t
module conv_index_gen
    import comp_seq_pkg::*;
(
    input  logic [1:0]  p_i,
    input  logic [3:0]  t_i,
    output logic [3:0]  pe_sel_a_o,
    output logic [35:0] cus_sel_o
);
    // Tap walks the window row-major; the custom PE sees the whole window at once
    always_comb begin
        pe_sel_a_o = elem_idx(p_i, 2'(t_i / 4'd3), 2'(t_i % 4'd3));
        cus_sel_o  = '0;
        for (int k = 0; k < N_TAP; k++) cus_sel_o[4*k +: 4] = elem_idx(p_i, 2'(k / 3), 2'(k % 3));
    end
endmodule

// File: rtl/computation_sequencer.sv
// computation_sequencer: control FSM for one computation_module job; COMP_SEQ_ABORT_EN adds ABORT input and ABT state
module computation_sequencer
    import comp_seq_pkg::*;
#(
    parameter int SYS_LAT = 4,
    parameter int CUS_LAT = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] MODE_REQ,
`ifdef COMP_SEQ_ABORT_EN
    input  logic       ABORT,
`endif
    output logic       BUSY,
    output logic       DONE,
    output logic       OUT_VALID,
    output logic [1:0] OUT_IDX,
    output logic [1:0] MODE,
    output logic       PRESET,
    output logic       PE_RST,
    output logic       SYS_RST,
    output logic       CUS_RST,
    output logic       PE_INIT,
    output logic       CUS_INIT,
    output logic       SYS_CACHE_WE_1,
    output logic       SYS_CACHE_WE_2,
    output logic [3:0] PE_SEL_A,
    output logic [3:0] PE_SEL_B,
    output logic [3:0] SYS_SEL_A,
    output logic [3:0] SYS_SEL_B,
    output logic [3:0] CUS_SEL_11,
    output logic [3:0] CUS_SEL_12,
    output logic [3:0] CUS_SEL_13,
    output logic [3:0] CUS_SEL_21,
    output logic [3:0] CUS_SEL_22,
    output logic [3:0] CUS_SEL_23,
    output logic [3:0] CUS_SEL_31,
    output logic [3:0] CUS_SEL_32,
    output logic [3:0] CUS_SEL_33
);
    localparam logic [3:0] SYS_LAST = 4'(SYS_LAT - 1);
    localparam logic [3:0] CUS_LAST = 4'(CUS_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d, p_q, p_d;
    logic [3:0]  t_q, t_d, w_q, w_d;
    logic [3:0]  pe_a_q, pe_b_q, sys_a_q, sys_b_q, idx_a;
    logic [35:0] cus_q, cus_sel, idx_cus;
    logic        busy, single, sys, cus, last_pix, abt;

    conv_index_gen u_idx (.p_i(p_q), .t_i(t_q), .pe_sel_a_o(idx_a), .cus_sel_o(idx_cus));

    assign busy     = state_q inside {CLR, MAC, LOAD_A, LOAD_B, WAIT, RES};
    assign single   = mode_q == MODE_SINGLE;
    assign sys      = mode_q == MODE_SYS;
    assign cus      = mode_q == MODE_CUS;
    assign last_pix = p_q == 2'(N_PIX - 1);
`ifdef COMP_SEQ_ABORT_EN
    assign abt = state_q == ABT;
`else
    assign abt = 1'b0;
`endif
    assign {CUS_SEL_33, CUS_SEL_32, CUS_SEL_31, CUS_SEL_23, CUS_SEL_22, CUS_SEL_21,
            CUS_SEL_13, CUS_SEL_12, CUS_SEL_11} = cus_sel;

    // State, counters and the held copies of every select
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mode_q  <= MODE_NONE;
            p_q     <= '0;
            t_q     <= '0;
            w_q     <= '0;
            pe_a_q  <= '0;
            pe_b_q  <= '0;
            sys_a_q <= '0;
            sys_b_q <= '0;
            cus_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            p_q     <= p_d;
            t_q     <= t_d;
            w_q     <= w_d;
            pe_a_q  <= PE_SEL_A;
            pe_b_q  <= PE_SEL_B;
            sys_a_q <= SYS_SEL_A;
            sys_b_q <= SYS_SEL_B;
            cus_q   <= cus_sel;
        end
    end

    // Phase sequencing: single/custom loop CLR..RES per pixel, systolic streams all pixels in RES
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        p_d     = p_q;
        t_d     = t_q;
        w_d     = w_q;
        case (state_q)
            IDLE: if (START && MODE_REQ != MODE_NONE) begin
                state_d = CLR;
                mode_d  = MODE_REQ;
                p_d     = '0;
            end
            CLR: begin
                state_d = sys ? LOAD_A : MAC;
                t_d     = '0;
            end
            MAC: begin
                state_d = cus ? WAIT : (t_q == 4'(N_TAP - 1)) ? RES : MAC;
                t_d     = t_q + 4'd1;
                w_d     = '0;
            end
            LOAD_A: begin
                state_d = (t_q == 4'(N_ROW_A - 1)) ? LOAD_B : LOAD_A;
                t_d     = (t_q == 4'(N_ROW_A - 1)) ? 4'd0 : t_q + 4'd1;
            end
            LOAD_B: begin
                state_d = (t_q == 4'(N_ROW_B - 1)) ? WAIT : LOAD_B;
                t_d     = t_q + 4'd1;
                w_d     = '0;
            end
            WAIT: begin
                state_d = (w_q == (sys ? SYS_LAST : CUS_LAST)) ? RES : WAIT;
                w_d     = w_q + 4'd1;
            end
            RES: begin
                state_d = last_pix ? IDLE : sys ? RES : CLR;
                p_d     = p_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
`ifdef COMP_SEQ_ABORT_EN
        if (ABORT && busy) state_d = ABT;
`endif
    end

    // Moore decode; selects follow their active phase, otherwise hold, and read 0 outside a job
    always_comb begin
        BUSY           = busy;
        MODE           = busy ? mode_q : MODE_NONE;
        PRESET         = state_q == CLR && p_q == 2'd0;
        PE_RST         = (state_q == CLR && single) || abt;
        SYS_RST        = (state_q == CLR && sys) || abt;
        CUS_RST        = (state_q == CLR && cus) || abt;
        PE_INIT        = state_q == MAC && single;
        CUS_INIT       = state_q == MAC && cus;
        SYS_CACHE_WE_1 = state_q == LOAD_A;
        SYS_CACHE_WE_2 = state_q == LOAD_B;
        OUT_VALID      = state_q == RES;
        OUT_IDX        = state_q == RES ? p_q : 2'd0;
        DONE           = state_q == RES && last_pix;
        PE_SEL_A       = !busy ? 4'd0 : (state_q == MAC && single) ? idx_a : pe_a_q;
        PE_SEL_B       = !busy ? 4'd0 : (state_q == MAC && single) ? t_q : pe_b_q;
        SYS_SEL_A      = !busy ? 4'd0 : state_q == LOAD_A ? t_q : (state_q == RES && sys) ? {2'b00, p_q} : sys_a_q;
        SYS_SEL_B      = !busy ? 4'd0 : state_q == LOAD_B ? t_q : sys_b_q;
        cus_sel        = !busy ? 36'd0 : (cus && state_q inside {MAC, WAIT, RES}) ? idx_cus : cus_q;
    end
endmodule

// File: doc/computation_sequencer.md
# computation_sequencer

Control sequencer for `computation_module`: drives every select, init, reset, write-enable and `MODE` input of the convolution datapath. It runs one 4x4 (input) by 3x3 (kernel) convolution, producing 2x2 = 4 result pixels, in the mode requested at `START`. It flags each pixel as it appears on the datapath `OUT` bus. It sits between the top-level command interface and `computation_module`, one instance per datapath.

## Interface
- `SYS_LAT`, default 4: wait cycles between the end of systolic loading and the first systolic result (1..15).
- `CUS_LAT`, default 2: wait cycles between `CUS_INIT` and the custom result (1..15).
- `CLK`  in  1  clock; single clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  job request; sampled only in IDLE.
- `MODE_REQ`  in  2  01 = single PE, 10 = systolic, 11 = custom; 00 = no job.
- `BUSY`  out  1  high from the first CLR cycle through the last RES cycle.
- `DONE`  out  1  one-cycle pulse coincident with the 4th `OUT_VALID`.
- `OUT_VALID`  out  1  the datapath `OUT` holds result pixel `OUT_IDX` this cycle.
- `OUT_IDX`  out  2  pixel index p; row pr = p>>1, column pc = p&1.
- `MODE`  out  2  equals the latched request while BUSY; 00 otherwise.
- `PRESET`  out  1  one-cycle pulse in the first CLR cycle of a job.
- `PE_RST`, `SYS_RST`, `CUS_RST`  out  1 each  datapath clears.
- `PE_INIT`, `CUS_INIT`  out  1 each  accumulate / capture strobes.
- `SYS_CACHE_WE_1`, `SYS_CACHE_WE_2`  out  1 each  systolic cache writes.
- `PE_SEL_A`, `PE_SEL_B`, `SYS_SEL_A`, `SYS_SEL_B`  out  4 each  element selects.
- `CUS_SEL_11` .. `CUS_SEL_33`  out  4 each  nine custom-PE input selects.

## Operation
- States: IDLE, CLR, MAC, LOAD_A, LOAD_B, WAIT, RES.
- Internal counters: pixel p (2 bit), tap t (0..8), load index, wait counter.
- IDLE → CLR on `START` with `MODE_REQ` ≠ 00; `MODE_REQ` is latched at that edge.
- `START` is ignored when `MODE_REQ` = 00 and whenever BUSY.
- Input element index, used by every mode: idx(p, r, c) = 4·(pr + r) + (pc + c), with r, c ∈ 0..2. Values are 4 bits and never exceed 15.
- Single (01), repeated for p = 0..3:
  - CLR: `PE_RST` = 1.
  - MAC, 9 cycles: `PE_INIT` = 1, `PE_SEL_B` = t, `PE_SEL_A` = idx(p, t/3, t%3).
  - RES: `OUT_VALID` = 1.
- Systolic (10), sequence:
  - CLR: `SYS_RST` = 1.
  - LOAD_A, 4 cycles: `SYS_CACHE_WE_1` = 1, `SYS_SEL_A` = 0..3.
  - LOAD_B, 3 cycles: `SYS_CACHE_WE_2` = 1, `SYS_SEL_B` = 0..2.
  - WAIT: `SYS_LAT` cycles.
  - RES, 4 cycles: `SYS_SEL_A` = p, `OUT_VALID` = 1.
- Custom (11), repeated for p = 0..3:
  - CLR: `CUS_RST` = 1.
  - INIT, 1 cycle (MAC state reused): `CUS_INIT` = 1.
  - WAIT: `CUS_LAT` cycles.
  - RES: 1 cycle.
  - `CUS_SEL_rc` = idx(p, r−1, c−1) from INIT through RES.
- Selects hold their last value outside their active phase. All other strobes are 0 unless listed.
- After the last RES the FSM returns to IDLE; `MODE` drops to 00 the following cycle.

## Timing
- All outputs are registered (Moore); every output is 0 in reset and in IDLE.
- `RST` mid-job: IDLE on the next edge; all outputs 0; the job is lost and `DONE` does not pulse.
- Job lengths, counted from the `START` edge to the `DONE` cycle inclusive:
  - Single: 4·11 = 44 cycles.
  - Systolic: 12 + `SYS_LAT` = 16 cycles at default.
  - Custom: 4·(3 + `CUS_LAT`) = 20 cycles at default.
- `START` asserted in the `DONE` cycle is ignored.
- Earliest next job: `START` sampled in the first IDLE cycle.

## Configuration
- `COMP_SEQ_ABORT_EN` defined: adds input `ABORT` (1 bit).
  - `ABORT` high while BUSY moves the FSM to CLR-like state ABT for one cycle: `PE_RST` = `SYS_RST` = `CUS_RST` = 1, `MODE` = 00, no `DONE`.
  - The FSM then goes to IDLE.
  - If `ABORT` and `RST` are both high, `RST` wins.
- Undefined: no `ABORT` port and no ABT state.

## Structure
- `comp_seq_pkg` holds:
  - the state enum;
  - mode codes `MODE_NONE`/`MODE_SINGLE`/`MODE_SYS`/`MODE_CUS`;
  - `N_PIX` = 4, `N_TAP` = 9, `N_ROW_A` = 4, `N_ROW_B` = 3;
  - function `elem_idx(p, r, c)`.
- One sub-module, `conv_index_gen`: combinational; pixel index and tap in, `PE_SEL_A` and the nine `CUS_SEL` values out.

## Test plan
- Single, `START` with `MODE_REQ` = 01:
  - `BUSY` for 44 cycles; `OUT_VALID` at cycles 11/22/33/44 with `OUT_IDX` 0..3.
  - Pixel 3 MAC emits `PE_SEL_A` = 5, 6, 7, 9, 10, 11, 13, 14, 15.
- Systolic, `MODE_REQ` = 10, `SYS_LAT` = 4:
  - WE_1 at cycles 2–5 with `SEL_A` 0..3; WE_2 at cycles 6–8 with `SEL_B` 0..2.
  - `OUT_VALID` at cycles 13–16; `DONE` at 16.
- Custom, `MODE_REQ` = 11: pixel 3 gives `CUS_SEL_11` = 5, `CUS_SEL_33` = 15; `DONE` at cycle 20.
- `START` with `MODE_REQ` = 00, and `START` repeated mid-job: no state change, job timing unchanged.
- `RST` at cycle 7 of a single job: all outputs 0 on the next cycle, no `DONE`; a fresh job afterwards runs the full 44 cycles.
- With `COMP_SEQ_ABORT_EN`: `ABORT` in systolic WAIT gives one cycle with all three resets high, then IDLE; no `DONE`.
